// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 Status/Cause/EPC with an optional Count/Compare timer.
// Define CP0_TIMER_EN to build the timer (regs 9/11, TI folded into IP[7]).
module cp0_regfile #(
    parameter int EXC_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       hwint,
    input  logic [31:0]      pcif,
    input  logic [31:0]      pcid,
    input  logic [31:0]      pcexe,
    input  logic [31:0]      pcmem,
    input  logic [1:0]       selepc,
    input  logic             writestatus,
    input  logic             writecause,
    input  logic             writeepc,
    input  logic             exl,
    input  logic             ie,
    input  logic             db,
    input  logic [EXC_W-1:0] exccode,
    input  logic             mfc0,
    input  logic             mtc0,
    input  logic [4:0]       c0addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             intr,
    output logic [7:0]       imip,
    output logic [31:0]      epc
);
    logic ie_q, ie_d, exl_q, exl_d, bd_q, bd_d;
    logic [7:0] im_q, im_d, ip;
    logic [EXC_W-1:0] exc_q, exc_d;
    logic [1:0] sw_q, sw_d;
    logic [5:0] hw_q;
    logic [31:0] epc_q, epc_d, epc_sel, status_w, cause_w, rd_tmr;
    logic wr_status, wr_cause, wr_epc;

    assign wr_status = mtc0 && c0addr == 5'd12;
    assign wr_cause  = mtc0 && c0addr == 5'd13;
    assign wr_epc    = mtc0 && c0addr == 5'd14;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic ti_q, ti_d, wr_compare;

    assign wr_compare = mtc0 && c0addr == 5'd11;
    assign ip = {hw_q[5] | ti_q, hw_q[4:0], sw_q};
    assign rd_tmr = c0addr == 5'd9 ? count_q : c0addr == 5'd11 ? compare_q : 32'd0;

    always_comb begin
        count_d   = (mtc0 && c0addr == 5'd9) ? wdata : count_q + 32'd1;
        compare_d = wr_compare ? wdata : compare_q;
        // A Compare write clears TI even if the match fires in the same cycle
        ti_d      = wr_compare ? 1'b0 : ti_q | (count_q == compare_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end
`else
    assign ip = {hw_q, sw_q};
    assign rd_tmr = 32'd0;
`endif

    always_comb begin
        ie_d    = writestatus ? ie  : wr_status ? wdata[0] : ie_q;
        exl_d   = writestatus ? exl : wr_status ? wdata[1] : exl_q;
        im_d    = (wr_status && !writestatus) ? wdata[15:8] : im_q;
        bd_d    = writecause ? db : bd_q;
        exc_d   = writecause ? exccode : exc_q;
        sw_d    = wr_cause ? wdata[9:8] : sw_q;
        epc_sel = selepc[1] ? (selepc[0] ? pcmem : pcexe) : (selepc[0] ? pcid : pcif);
        epc_d   = writeepc ? epc_sel : wr_epc ? wdata : epc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q  <= 1'b0;
            exl_q <= 1'b0;
            im_q  <= 8'd0;
            bd_q  <= 1'b0;
            exc_q <= '0;
            sw_q  <= 2'd0;
            hw_q  <= 6'd0;
            epc_q <= 32'd0;
        end else begin
            ie_q  <= ie_d;
            exl_q <= exl_d;
            im_q  <= im_d;
            bd_q  <= bd_d;
            exc_q <= exc_d;
            sw_q  <= sw_d;
            hw_q  <= hwint;
            epc_q <= epc_d;
        end
    end

    assign status_w = {16'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_w  = {bd_q, 15'd0, ip, 1'b0, 5'(exc_q), 2'd0};
    assign rdata = !mfc0 ? 32'd0 : c0addr == 5'd12 ? status_w : c0addr == 5'd13 ? cause_w :
                   c0addr == 5'd14 ? epc_q : rd_tmr;
    assign intr = ie_q & ~exl_q;
    assign imip = ip & im_q;
    assign epc  = epc_q;
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed test-plan sequence plus random traffic against an
// architectural register-array model of CP0.
module tb_cp0_regfile;
    logic clk = 1'b0, rst;
    logic [5:0] hwint;
    logic [31:0] pcif, pcid, pcexe, pcmem, wdata, rdata, epc;
    logic [1:0] selepc;
    logic writestatus, writecause, writeepc, exl, ie, db, mfc0, mtc0, intr;
    logic [4:0] exccode, c0addr;
    logic [7:0] imip;
    int checks = 0, errors = 0;

    logic [31:0] cp0 [32];
    logic [5:0] hw_m;
    logic ti_m;

    cp0_regfile #(.EXC_W(5)) dut (
        .clk(clk), .rst(rst), .hwint(hwint), .pcif(pcif), .pcid(pcid), .pcexe(pcexe),
        .pcmem(pcmem), .selepc(selepc), .writestatus(writestatus), .writecause(writecause),
        .writeepc(writeepc), .exl(exl), .ie(ie), .db(db), .exccode(exccode), .mfc0(mfc0),
        .mtc0(mtc0), .c0addr(c0addr), .wdata(wdata), .rdata(rdata), .intr(intr),
        .imip(imip), .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_ip();
        return {hw_m[5] | ti_m, hw_m[4:0], cp0[13][9:8]};
    endfunction

    function automatic logic [31:0] m_rd();
        logic [7:0] p;
        p = m_ip();
        if (!mfc0) return 32'd0;
        if (c0addr == 5'd13) return cp0[13] | {16'd0, p, 8'd0};
        return cp0[c0addr];
    endfunction

    task automatic m_reset();
        foreach (cp0[i]) cp0[i] = 32'd0;
`ifdef CP0_TIMER_EN
        cp0[11] = 32'hFFFF_FFFF;
`endif
        hw_m = 6'd0;
        ti_m = 1'b0;
    endtask

    task automatic m_step();
        logic [31:0] n [32];
        logic [31:0] pcs [4];
        pcs = '{pcif, pcid, pcexe, pcmem};
        n = cp0;
        if (mtc0 && c0addr == 5'd12 && !writestatus) n[12] = wdata & 32'h0000_FF03;
        if (mtc0 && c0addr == 5'd13) n[13] = (n[13] & ~32'h300) | (wdata & 32'h300);
        if (mtc0 && c0addr == 5'd14 && !writeepc) n[14] = wdata;
        if (writestatus) n[12] = (cp0[12] & 32'hFF00) | {30'd0, exl, ie};
        if (writecause) n[13] = (n[13] & 32'h300) | {db, 24'd0, exccode, 2'd0};
        if (writeepc) n[14] = pcs[selepc];
`ifdef CP0_TIMER_EN
        n[9] = (mtc0 && c0addr == 5'd9) ? wdata : cp0[9] + 32'd1;
        if (mtc0 && c0addr == 5'd11) begin
            n[11] = wdata;
            ti_m = 1'b0;
        end else if (cp0[9] == cp0[11]) ti_m = 1'b1;
`endif
        hw_m = hwint;
        cp0 = n;
    endtask

    task automatic cycle();
        logic [7:0] p;
        @(negedge clk);
        p = m_ip();
        chk("rdata", rdata, m_rd());
        chk("intr", {31'd0, intr}, {31'd0, cp0[12][0] & ~cp0[12][1]});
        chk("imip", {24'd0, imip}, {24'd0, p & cp0[12][15:8]});
        chk("epc", epc, cp0[14]);
        @(posedge clk);
        if (rst) m_reset(); else m_step();
        #1;
    endtask

    task automatic idle();
        {writestatus, writecause, writeepc, mfc0, mtc0} = 5'd0;
    endtask

    task automatic mtc(input logic [4:0] a, input logic [31:0] d);
        mtc0 = 1'b1;
        c0addr = a;
        wdata = d;
        cycle();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        hwint = 6'd0;
        {pcif, pcid, pcexe, pcmem, wdata} = '0;
        {selepc, exl, ie, db, exccode, c0addr} = '0;
        idle();
        m_reset();
        repeat (2) cycle();
        rst = 1'b0;
        mfc0 = 1'b1;
        c0addr = 5'd12;
        #1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_imip", {24'd0, imip}, 32'd0);
        idle();
        cycle();

        mtc(5'd12, 32'h0000_FF01);
        chk("tp_intr_on", {31'd0, intr}, 32'd1);
        chk("tp_imip_pre", {24'd0, imip}, 32'd0);
        hwint = 6'b000001;
        cycle();
        chk("tp_imip_hw", {24'd0, imip}, 32'h04);

        {writestatus, writecause, writeepc} = 3'b111;
        {ie, exl, db, exccode, selepc, pcid} = {1'b0, 1'b0, 1'b1, 5'd0, 2'b01, 32'h0040_0010};
        cycle();
        idle();
        chk("entry_epc", epc, 32'h0040_0010);
        chk("entry_intr", {31'd0, intr}, 32'd0);
        mfc0 = 1'b1;
        c0addr = 5'd13;
        #1;
        chk("entry_cause", rdata, 32'h8000_0400);
        cycle();

        {writestatus, writecause, exl, ie, db, exccode} = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8};
        cycle();
        idle();
        chk("sys_intr", {31'd0, intr}, 32'd0);
        mfc0 = 1'b1;
        c0addr = 5'd13;
        #1;
        chk("sys_exc", (rdata >> 2) & 32'h1F, 32'd8);
        idle();
        {writestatus, exl, ie} = 3'b101;
        cycle();
        idle();
        chk("eret_intr", {31'd0, intr}, 32'd1);

        {writeepc, selepc, pcmem} = {1'b1, 2'b11, 32'h100};
        mtc(5'd14, 32'h200);
        chk("conflict_epc", epc, 32'h100);

`ifdef CP0_TIMER_EN
        hwint = 6'd0;
        mtc(5'd12, 32'h0000_8001);
        mtc(5'd11, 32'h0000_0001);
        mtc(5'd9, 32'hFFFF_FFFE);
        repeat (3) cycle();
        chk("tmr_pre", {24'd0, imip}, 32'd0);
        cycle();
        chk("tmr_ti", {24'd0, imip}, 32'h80);
        mtc(5'd11, 32'h0000_0100);
        chk("tmr_clr", {24'd0, imip}, 32'd0);
`endif

        mfc0 = 1'b1;
        c0addr = 5'd5;
        #1;
        chk("rd_unimpl", rdata, 32'd0);
        mfc0 = 1'b0;
        c0addr = 5'd12;
        #1;
        chk("rd_nomfc0", rdata, 32'd0);
        cycle();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) hwint = 6'($urandom);
            {pcif, pcid, pcexe, pcmem} = {$urandom, $urandom, $urandom, $urandom};
            selepc = 2'($urandom);
            writestatus = $urandom_range(0, 5) == 0;
            writecause = $urandom_range(0, 5) == 0;
            writeepc = $urandom_range(0, 5) == 0;
            {ie, exl, db} = 3'($urandom);
            exccode = 5'($urandom);
            mfc0 = 1'($urandom);
            case ($urandom_range(0, 7))
                0: c0addr = 5'd9;
                1: c0addr = 5'd11;
                2: c0addr = 5'd12;
                3: c0addr = 5'd13;
                4: c0addr = 5'd14;
                default: c0addr = 5'($urandom);
            endcase
            mtc0 = $urandom_range(0, 3) == 0;
            wdata = $urandom;
            if (c0addr == 5'd11 && $urandom_range(0, 1) == 1) wdata = cp0[9] + $urandom_range(1, 3);
            cycle();
        end

        idle();
        mtc(5'd14, 32'hDEAD_0000);
        mtc(5'd12, 32'h0000_FF01);
        mfc0 = 1'b1;
        c0addr = 5'd14;
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        chk("arst_epc", epc, 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        chk("arst_intr", {31'd0, intr}, 32'd0);
        chk("arst_imip", {24'd0, imip}, 32'd0);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the five-stage MIPS pipeline. It holds Status, Cause, EPC and the optional Count/Compare timer, and serves mfc0/mtc0 from the ID stage. It consumes the exception and interrupt strobes produced by ID-stage decode, and feeds back the interrupt request, the masked pending vector and EPC for eret redirection.

## Interface
Parameters:
- `EXC_W`, default 5: ExcCode field width.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `hwint` in 6: external interrupt lines, level-sensitive, mapped to IP[7:2].
- `pcif`, `pcid`, `pcexe`, `pcmem` in 32 each: stage PCs, used as EPC sources.
- `selepc` in 2: EPC source select. 00 = pcif, 01 = pcid, 10 = pcexe, 11 = pcmem.
- `writestatus`, `writecause`, `writeepc` in 1 each: exception/eret update strobes.
- `exl`, `ie` in 1 each: new Status.EXL and Status.IE values, applied on writestatus.
- `db` in 1: new Cause.BD value.
- `exccode` in EXC_W: new Cause.ExcCode value.
- `mfc0`, `mtc0` in 1 each: CP0 read and write strobes.
- `c0addr` in 5: CP0 register number (rd field).
- `wdata` in 32: mtc0 data.
- `rdata` out 32: mfc0 data, combinational.
- `intr` out 1: Status.IE & ~Status.EXL.
- `imip` out 8: Cause.IP & Status.IM.
- `epc` out 32: current EPC.

## Operation
- Status (reg 12): bit0 IE, bit1 EXL, bits15:8 IM. All other bits read 0.
- Cause (reg 13): bit31 BD, bits15:8 IP, bits6:2 ExcCode. All other bits read 0.
- EPC (reg 14): 32 bits.
- Count (reg 9) and Compare (reg 11) are present only with the timer macro.
- IP[7:2] is registered every cycle from hwint. With the timer macro, IP[7] = hwint[5] | TI.
- IP[1:0] are software bits, written only by mtc0 Cause.
- writestatus: IE <= ie, EXL <= exl. IM is unchanged.
- mtc0 Status writes IE, EXL and IM from wdata.
- If writestatus and mtc0 Status occur in the same cycle, writestatus wins entirely.
- writecause: BD <= db, ExcCode <= exccode. IP is unchanged.
- mtc0 Cause writes IP[1:0] only. A simultaneous writecause still applies, because the fields are disjoint.
- writeepc: EPC <= source selected by selepc. mtc0 EPC writes wdata. writeepc wins a same-cycle conflict.
- mtc0 to any other address: ignored.
- rdata: when mfc0 = 1, returns the current register value (pre-update) for c0addr. Unimplemented addresses return 0. When mfc0 = 0, rdata is 0.
- No same-cycle write-to-read bypass.

## Timing
- Reset values: Status = 0, Cause = 0, EPC = 0, Count = 0, Compare = 0xFFFFFFFF, TI = 0.
- Reset outputs: intr = 0, imip = 0, epc = 0, rdata = 0.
- All register updates take effect on the clock edge after the strobe. intr, imip and epc reflect them the following cycle.
- hwint to imip latency: 1 cycle (registered sample).
- Count increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
- mtc0 Count loads wdata with no increment that cycle.
- TI sets on the edge after registered Count == Compare and stays set until cleared.
- mtc0 Compare writes Compare and clears TI. If a match and a Compare write coincide, the clear wins.
- Reset asserted mid-operation clears all state immediately (asynchronous), including a pending TI. There is no partial update on the reset edge.

## Configuration
- `CP0_TIMER_EN` defined:
  - Count and Compare registers exist.
  - TI is ORed into IP[7].
  - Addresses 9 and 11 are readable and writable.
- `CP0_TIMER_EN` undefined:
  - No Count, Compare or TI logic.
  - IP[7] = hwint[5].
  - Addresses 9 and 11 read 0 and ignore writes.

## Test plan
- Reset, then mtc0 Status = 0x0000FF01, then hwint = 6'b000001 → intr = 1 one cycle after the write; imip = 0x04 one cycle after hwint rises.
- Interrupt entry: writestatus, writecause and writeepc together with ie = 0, exl = 0, db = 1, exccode = 0, selepc = 01, pcid = 0x00400010 → next cycle epc = 0x00400010, intr = 0, mfc0 Cause reads 0x80000000 | IP bits.
- Syscall then eret: first cycle exl = 1, ie = 1, exccode = 8 → intr = 0 and Cause[6:2] = 8. Then writestatus with exl = 0, ie = 1 → intr = 1.
- Conflict: writeepc (selepc = 11, pcmem = 0x100) and mtc0 EPC = 0x200 in the same cycle → epc = 0x100.
- Timer (CP0_TIMER_EN): mtc0 Count = 0xFFFFFFFE, Compare = 0x00000001 with IM[7] = 1 → Count wraps to 0, matches at 1, TI and imip[7] = 1 one cycle later. mtc0 Compare then clears imip[7].
- mfc0 to address 5 → rdata = 0. mfc0 = 0 → rdata = 0 regardless of c0addr.
